// File: rtl/cache_line_arbiter_if.sv
// Bundle of the I-side, D-side and downstream memory signals of cache_line_arbiter.
// The arbiter takes the slave modport; the caches/memory environment takes master.
interface cache_line_arbiter_if #(
    parameter int s_line = 256,
    parameter int s_addr = 32
);
    logic              i_read;
    logic [s_addr-1:0] i_address;
    logic              i_resp;
    logic [s_line-1:0] i_rdata;

    logic              d_read;
    logic              d_write;
    logic [s_addr-1:0] d_address;
    logic [s_line-1:0] d_wdata;
    logic              d_resp;
    logic [s_line-1:0] d_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [s_addr-1:0] mem_address;
    logic [s_line-1:0] mem_wdata;
    logic              mem_resp;
    logic [s_line-1:0] mem_rdata;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata, mem_resp, mem_rdata,
        output i_resp, i_rdata, d_resp, d_rdata, mem_read, mem_write, mem_address, mem_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata, mem_resp, mem_rdata,
        input  i_resp, i_rdata, d_resp, d_rdata, mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/cache_line_arbiter.sv
// Shares one line-wide memory port between I-cache and D-cache, D write-back chained to its refill.
// CACHE_ARB_ROUND_ROBIN_EN selects round-robin arbitration; default is fixed D-over-I priority.
module cache_line_arbiter #(
    parameter int s_line = 256,
    parameter int s_addr = 32
) (
    input logic           clk,
    input logic           rst_n,
    cache_line_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;

    logic [1:0]        state;
    logic              wb_chain;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [s_addr-1:0] addr_q;
    logic [s_line-1:0] wdata_q;

    logic i_req;
    logic d_req;
    logic take;
    logic favour_d;
    logic pick_d;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;
    assign take  = (state == IDLE) && (i_req || d_req);

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    // ptr_d set means D holds priority on the next contended arbitration.
    logic ptr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr_d <= 1'b0;
        else if (take)
            ptr_d <= !pick_d;
    end

    assign favour_d = ptr_d;
`else
    assign favour_d = 1'b1;
`endif

    // A pending write-back chain forces D ahead of I so its refill follows immediately.
    assign pick_d = d_req && (!i_req || wb_chain || favour_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wb_chain    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Either a grant is taken or nothing (and so no D) requested: chain ends.
                    wb_chain <= 1'b0;
                    if (take) begin
                        state       <= pick_d ? GRANT_D : GRANT_I;
                        mem_write_q <= pick_d & bus.d_write;
                        mem_read_q  <= !(pick_d & bus.d_write);
                        addr_q      <= pick_d ? bus.d_address : bus.i_address;
                        if (pick_d)
                            wdata_q <= bus.d_wdata;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (bus.mem_resp) begin
                        state       <= IDLE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        wb_chain    <= (state == GRANT_D) & mem_write_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_wdata   = wdata_q;

    assign bus.i_resp  = (state == GRANT_I) & bus.mem_resp;
    assign bus.d_resp  = (state == GRANT_D) & bus.mem_resp;
    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_cache_line_arbiter.sv
// Bench for cache_line_arbiter: transaction-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cache_line_arbiter;
    localparam int LW = 256;
    localparam int AW = 32;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    localparam logic FIXED_PRIO = 1'b0;
`else
    localparam logic FIXED_PRIO = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_line_arbiter_if #(.s_line(LW), .s_addr(AW)) bus();
    cache_line_arbiter #(.s_line(LW), .s_addr(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [LW:0] act, input logic [LW:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } op_t;
    op_t op_log[$];

    // ---------------- reference model (one outstanding transaction) ----------------
    logic          m_busy = 0, m_own_d = 0, m_wr = 0, m_chain = 0, m_ptr_d = 0;
    logic [AW-1:0] m_addr = '0;
    logic [LW-1:0] m_wdata = '0;
    logic          m_dw;

    function automatic logic d_wins(input logic ir, input logic dr, input logic chain,
                                    input logic ptr_d);
        if (!dr) return 1'b0;
        if (!ir) return 1'b1;
        if (chain) return 1'b1;
        return ptr_d | FIXED_PRIO;
    endfunction

    assign m_dw = d_wins(bus.i_read, bus.d_read | bus.d_write, m_chain, m_ptr_d);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_own_d <= 0; m_wr <= 0; m_chain <= 0; m_ptr_d <= 0;
        end else if (!m_busy) begin
            m_chain <= 0;
            if (bus.i_read || bus.d_read || bus.d_write) begin
                m_busy  <= 1;
                m_own_d <= m_dw;
                m_wr    <= m_dw && bus.d_write;
                m_addr  <= m_dw ? bus.d_address : bus.i_address;
                m_wdata <= bus.d_wdata;
                m_ptr_d <= !m_dw;
            end
        end else if (bus.mem_resp) begin
            m_busy  <= 0;
            m_chain <= m_own_d && m_wr;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_ctrl", {bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp}, 0);
            check("reset_regs", (LW+1)'(bus.mem_address) | (LW+1)'(bus.mem_wdata), 0);
        end else begin
            check("mem_read", bus.mem_read, m_busy && !m_wr);
            check("mem_write", bus.mem_write, m_busy && m_wr);
            if (m_busy) check("mem_address", bus.mem_address, m_addr);
            if (m_busy && m_wr) check("mem_wdata", bus.mem_wdata, m_wdata);
            check("i_resp", bus.i_resp, m_busy && !m_own_d && bus.mem_resp);
            check("d_resp", bus.d_resp, m_busy && m_own_d && bus.mem_resp);
            if (m_busy && bus.mem_resp && !m_wr) begin
                if (m_own_d) check("d_rdata", bus.d_rdata, bus.mem_rdata);
                else         check("i_rdata", bus.i_rdata, bus.mem_rdata);
            end
            if (bus.mem_resp && (bus.mem_read || bus.mem_write))
                op_log.push_back('{bus.mem_write, bus.mem_address, bus.mem_wdata});
        end
    end

    // ---------------- memory responder ----------------
    int   lat_cfg = 3;
    int   cnt     = 0;
    logic spur_en = 0;

    function automatic int next_lat();
        return (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
    endfunction

    initial begin
        bus.mem_resp  = 0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            for (int w = 0; w < LW/32; w++) bus.mem_rdata[w*32 +: 32] = $urandom();
            if (!rst_n) begin
                bus.mem_resp = 0;
                cnt = next_lat();
            end else if (bus.mem_resp) begin
                bus.mem_resp = 0;
            end else if (bus.mem_read || bus.mem_write) begin
                if (cnt == 0) begin
                    bus.mem_resp = 1;
                    cnt = next_lat();
                end else cnt--;
            end else if (spur_en && $urandom_range(0, 7) == 0) begin
                bus.mem_resp = 1;
            end
        end
    end

    // ---------------- cache-side drivers (called at posedge+1) ----------------
    task automatic i_txn(input logic [AW-1:0] a);
        int t = 0;
        bus.i_read = 1; bus.i_address = a;
        do begin @(negedge clk); t++; end while (!bus.i_resp && t < 200);
        check("i_handshake", bus.i_resp, 1);
        @(posedge clk); #1;
        bus.i_read = 0;
    endtask

    task automatic d_txn(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [LW-1:0] data);
        int t = 0;
        bus.d_read = rd; bus.d_write = wr; bus.d_address = a; bus.d_wdata = data;
        do begin @(negedge clk); t++; end while (!bus.d_resp && t < 200);
        check("d_handshake", bus.d_resp, 1);
        @(posedge clk); #1;
        bus.d_read = 0; bus.d_write = 0;
    endtask

    task automatic check_op(input string name, input int idx, input logic wr,
                            input logic [AW-1:0] a);
        if (idx < op_log.size()) check(name, {op_log[idx].wr, op_log[idx].addr}, {wr, a});
        else check(name, op_log.size(), idx + 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        check("async_reset_ctrl", {bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp}, 0);
        check("async_reset_regs", (LW+1)'(bus.mem_address) | (LW+1)'(bus.mem_wdata), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int w = 0; w < LW/32; w++) v[w*32 +: 32] = $urandom();
        return v;
    endfunction

    logic [5:0] rd_seen, resp_seen;
    logic       dresp_any;

    initial begin
        bus.i_read = 0; bus.i_address = '0;
        bus.d_read = 0; bus.d_write = 0; bus.d_address = '0; bus.d_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // Single I read at 0x40, latency 3
        bus.i_read = 1; bus.i_address = 32'h40;
        rd_seen = '0; resp_seen = '0; dresp_any = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rd_seen[k] = bus.mem_read;
            resp_seen[k] = bus.i_resp;
            dresp_any |= bus.d_resp;
            if (bus.mem_read) check("t1_addr", bus.mem_address, 32'h40);
            if (bus.i_resp) check("t1_rdata", bus.i_rdata, bus.mem_rdata);
            @(posedge clk); #1;
            if (resp_seen[k]) bus.i_read = 0;
        end
        check("t1_read_window", rd_seen, 6'b011110);
        check("t1_resp_cycle", resp_seen, 6'b010000);
        check("t1_no_dresp", dresp_any, 0);

        // Simultaneous I 0x100 and D 0x200 from a fresh reset
        do_reset();
        op_log.delete();
        fork
            i_txn(32'h100);
            d_txn(1, 0, 32'h200, '0);
        join
        check("t2_count", op_log.size(), 2);
        check_op("t2_first", 0, 0, FIXED_PRIO ? 32'h200 : 32'h100);
        check_op("t2_second", 1, 0, FIXED_PRIO ? 32'h100 : 32'h200);

        // Write-back then refill stays back-to-back while I keeps asking
        op_log.delete();
        fork
            begin
                d_txn(0, 1, 32'h300, {32{8'hA5}});
                d_txn(1, 0, 32'h400, '0);
            end
            begin
                @(posedge clk); #1;
                i_txn(32'h500);
            end
        join
        check("t3_count", op_log.size(), 3);
        check_op("t3_wb", 0, 1, 32'h300);
        if (op_log.size() > 0) check("t3_wb_data", op_log[0].wdata, {32{8'hA5}});
        check_op("t3_refill", 1, 0, 32'h400);
        check_op("t3_ifetch", 2, 0, 32'h500);

        // d_read and d_write together issue only the write
        op_log.delete();
        d_txn(1, 1, 32'h640, rand_line());
        check("t4_count", op_log.size(), 1);
        check_op("t4_write_only", 0, 1, 32'h640);

        // I address moves mid-grant; downstream keeps the latched one
        op_log.delete();
        fork
            i_txn(32'h600);
            begin
                repeat (2) @(posedge clk);
                #1 bus.i_address = 32'h700;
            end
        join
        check_op("t5_latched", 0, 0, 32'h600);

        // Reset in the middle of a D grant
        bus.d_read = 1; bus.d_address = 32'h800;
        @(posedge clk); #1;
        check("t6_granted", {bus.mem_read, bus.mem_address}, {1'b1, 32'h800});
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        check("t6_async_ctrl", {bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp}, 0);
        check("t6_async_regs", (LW+1)'(bus.mem_address) | (LW+1)'(bus.mem_wdata), 0);
        bus.d_read = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        op_log.delete();
        i_txn(32'h900);
        check("t6_count", op_log.size(), 1);
        check_op("t6_after_reset", 0, 0, 32'h900);

        // Randomized traffic, random latency, stray mem_resp while idle
        lat_cfg = -1;
        spur_en = 1;
        fork
            for (int k = 0; k < 150; k++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                i_txn($urandom() & 32'hFFFF_FFE0);
            end
            for (int k = 0; k < 150; k++) begin
                int r;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                r = $urandom_range(0, 9);
                d_txn(r < 5 || r == 9, r >= 5, $urandom() & 32'hFFFF_FFE0, rand_line());
            end
        join
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_line_arbiter.md
# cache_line_arbiter

Two-requester, line-granular arbiter sharing one downstream memory port between the instruction-side and data-side pipelined caches. Each cache's downstream interface connects to one upstream port here, and the single downstream port drives L2/physical memory. The arbiter latches the winning request, holds downstream signals stable until `mem_resp`, and routes the response back to the winner. It also keeps a data-side write-back and its refill read back-to-back.

## Interface
- `s_line`, 256, line width in bits
- `s_addr`, 32, address width in bits
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `i_read`  in  1  I-cache line read request
- `i_address`  in  s_addr  I-cache line address
- `i_resp`  out  1  I-side transaction complete
- `i_rdata`  out  s_line  I-side read data
- `d_read`, `d_write`  in  1 each  D-cache line read / write-back request
- `d_address`  in  s_addr  D-cache line address
- `d_wdata`  in  s_line  D-cache write-back data
- `d_resp`  out  1  D-side transaction complete
- `d_rdata`  out  s_line  D-side read data
- `mem_read`, `mem_write`  out  1 each  downstream request
- `mem_address`  out  s_addr  downstream address
- `mem_wdata`  out  s_line  downstream write data
- `mem_resp`  in  1  downstream completion
- `mem_rdata`  in  s_line  downstream read data

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE:
  - Samples `i_read`, `d_read | d_write`; picks a winner by the arbitration rule.
  - On the clock edge, latches the winner's address (and `d_wdata` and the write flag for D) into output registers and moves to GRANT_I or GRANT_D.
  - With no request, stays in IDLE.
- GRANT_x:
  - `mem_read`/`mem_write`/`mem_address`/`mem_wdata` come from registers only and stay constant until `mem_resp`.
  - On `mem_resp`, the winner's `x_resp` = 1 the same cycle, combinationally. `x_rdata` = `mem_rdata` passes through for reads.
  - The next state is IDLE.
- The losing port's `resp` stays 0. Its `rdata` = `mem_rdata`, which is don't-care.
- Upstream ports must hold their request stable until their `resp`. The arbiter never drops a latched request.
- D with `d_read` and `d_write` both high: the write is issued and the read is ignored.
- Write-back chaining:
  - Completing a D write sets the `wb_chain` flag.
  - While `wb_chain` = 1, D wins the next IDLE arbitration regardless of the rule.
  - `wb_chain` clears when any grant is taken, or after one IDLE cycle with no D request.
- Reset (`rst_n` low, any time): state IDLE, `wb_chain` = 0, priority pointer = I.
  - All outputs go to 0 immediately: `mem_read`, `mem_write`, `i_resp`, `d_resp`, address and wdata registers.
  - A downstream transaction in flight is abandoned. The downstream side must tolerate this.

## Timing
- Request visible in IDLE at cycle 0 → `mem_read`/`mem_write` high from cycle 1.
- `mem_resp` at cycle N → `x_resp` high at cycle N only. Downstream request low at N+1 (IDLE).
- Minimum turnaround is 1 IDLE cycle between consecutive grants. The best-case transaction is 2 cycles plus memory latency.
- `mem_resp` while IDLE is ignored: no upstream `resp` is generated.
- A request arriving in the same cycle as `mem_resp` is arbitrated in the following IDLE cycle.

## Configuration
- `CACHE_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin with a 1-bit priority pointer, updated on every grant to favour the non-granted port.
  - On simultaneous requests, the pointer side wins.
- Undefined: fixed priority, D over I always.
- `wb_chain` override applies in both builds.

## Test plan
- Single I read at 0x0000_0040, memory latency 3 → `mem_read` high cycles 1–4, `mem_address` 0x40, `i_resp` at cycle 4 with `i_rdata` = `mem_rdata`; `d_resp` stays 0.
- Simultaneous I read 0x100 and D read 0x200, fixed priority → D served first (0x200), then after one IDLE cycle I (0x100). Round-robin build with pointer = I after reset → I first, then D.
- D write-back 0x300 with data pattern 0xA5… followed by D refill read 0x400 while I continuously requests 0x500 → sequence on memory is write 0x300, read 0x400, read 0x500, in both builds.
- `d_read` and `d_write` both high → only `mem_write` asserted, `mem_read` stays 0.
- Change `i_address` mid-grant → `mem_address` stays at the latched value until `mem_resp`.
- `rst_n` asserted mid-GRANT_D → all outputs 0 asynchronously. After release, a new I request is granted from IDLE normally.
